dmem_bank_pipelined: RTL and testbench

- Parametrised synchronous data memory for the processor datapath.
- Successor to the fixed 16-bit x 256 data bank.
- Adds configurable width, depth and read latency, per-byte write enables, a valid/ready request handshake, in-order pipelined responses, out-of-range detection, and a self-timed post-reset initialisation sweep.

---
 rtl/dmem_pkg.sv | 13 +
 rtl/dmem_rd_pipe.sv | 53 +++++
 rtl/dmem_bank_pipelined.sv | 122 ++++++++++++
 tb/tb_dmem_bank_pipelined.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the pipelined data memory bank.
package dmem_pkg;

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_e;

    localparam int unsigned INIT_ZERO    = 0;
    localparam int unsigned INIT_INDEX   = 1;
    localparam int unsigned READ_LAT_MAX = 4;

endpackage

// File: rtl/dmem_rd_pipe.sv
// Fixed-latency response pipeline carrying {valid, err, data}; rst flushes every stage.
module dmem_rd_pipe #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned LAT    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic              err_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic              err_o,
    output logic [DATA_W-1:0] data_o
);

    logic [LAT-1:0]    valid_q, valid_d;
    logic [LAT-1:0]    err_q, err_d;
    logic [DATA_W-1:0] data_q [LAT];
    logic [DATA_W-1:0] data_d [LAT];

    always_comb begin
        valid_d    = valid_q;
        err_d      = err_q;
        data_d     = data_q;
        valid_d[0] = valid_i;
        err_d[0]   = err_i;
        data_d[0]  = data_i;
        for (int i = 1; i < LAT; i++) begin
            valid_d[i] = valid_q[i-1];
            err_d[i]   = err_q[i-1];
            data_d[i]  = data_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            err_q   <= '0;
            for (int i = 0; i < LAT; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            err_q   <= err_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q[LAT-1];
    assign err_o   = err_q[LAT-1];
    assign data_o  = data_q[LAT-1];

endmodule

// File: rtl/dmem_bank_pipelined.sv
// Parametrised data memory with byte-enable writes, pipelined in-order responses,
// out-of-range detection and a self-timed fill sweep after reset.
module dmem_bank_pipelined
    import dmem_pkg::*;
#(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned DEPTH     = 256,
    parameter int unsigned READ_LAT  = 1,
    parameter int unsigned INIT_MODE = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                init_busy
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    state_e            state_q, state_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;

    logic              accept;
    logic              in_range;
    logic [IDX_W-1:0]  req_idx;
    logic              mem_we;
    logic [IDX_W-1:0]  mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              pipe_err;
    logic [DATA_W-1:0] pipe_data;

    // Compare at ADDR_W+1 bits so DEPTH == 2**ADDR_W is representable.
    assign in_range = {1'b0, req_addr} < (ADDR_W + 1)'(DEPTH);
    assign req_idx  = req_addr[IDX_W-1:0];
    assign accept   = req_valid & req_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == S_INIT) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == IDX_W'(DEPTH - 1)) begin
                state_d = S_RUN;
            end
        end
    end

    always_comb begin
        req_ready = (state_q == S_RUN);
        init_busy = (state_q == S_INIT);
    end

    // Single write port shared by the fill sweep and request writes.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = cnt_q;
        mem_wdata = (INIT_MODE == INIT_INDEX) ? DATA_W'(cnt_q) : '0;
        if (state_q == S_INIT) begin
            mem_we = ~rst;
        end else if (accept && req_write && in_range) begin
            mem_we    = 1'b1;
            mem_waddr = req_idx;
            mem_wdata = mem_q[req_idx];
            for (int k = 0; k < BE_W; k++) begin
                if (req_be[k]) begin
                    mem_wdata[8*k +: 8] = req_wdata[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    // Read data is taken from the array as it stands at the accept edge, which already
    // holds any write accepted on the previous edge.
    always_comb begin
        pipe_err  = accept & ~in_range;
        pipe_data = '0;
        if (accept && !req_write && in_range) begin
            pipe_data = mem_q[req_idx];
        end
    end

    dmem_rd_pipe #(
        .DATA_W (DATA_W),
        .LAT    (READ_LAT)
    ) u_rd_pipe (
        .clk     (clk),
        .rst     (rst),
        .valid_i (accept),
        .err_i   (pipe_err),
        .data_i  (pipe_data),
        .valid_o (rsp_valid),
        .err_o   (rsp_err),
        .data_o  (rsp_rdata)
    );

endmodule

// File: tb/tb_dmem_bank_pipelined.sv
// Scoreboard bench: each issued request queues its expected response and due cycle;
// a negedge monitor pops and compares every response the DUT presents.
module tb_dmem_bank_pipelined;

    localparam int unsigned DATA_W   = 16;
    localparam int unsigned ADDR_W   = 16;
    localparam int unsigned DEPTH    = 256;
    localparam int unsigned READ_LAT = 2;

    typedef struct {
        string       name;
        logic        err;
        logic [15:0] data;
        int          due;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  req_be;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        init_busy;

    logic        z_req_ready;
    logic        z_rsp_valid;
    logic [15:0] z_rsp_rdata;
    logic        z_rsp_err;
    logic        z_init_busy;

    exp_t expq[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    dmem_bank_pipelined #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .DEPTH     (DEPTH),
        .READ_LAT  (READ_LAT),
        .INIT_MODE (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .init_busy (init_busy)
    );

    // Zero-fill variant, driven in lockstep; only its post-init read is checked.
    dmem_bank_pipelined #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .DEPTH     (DEPTH),
        .READ_LAT  (READ_LAT),
        .INIT_MODE (0)
    ) dut_zero (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (z_req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (z_rsp_valid),
        .rsp_rdata (z_rsp_rdata),
        .rsp_err   (z_rsp_err),
        .init_busy (z_init_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        if (rsp_valid) begin
            checks++;
            if (expq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rsp: got err=%0b data=%h at cyc %0d, required no response",
                         rsp_err, rsp_rdata, cyc);
            end else begin
                e = expq.pop_front();
                if (rsp_err !== e.err || rsp_rdata !== e.data || cyc != e.due) begin
                    errors++;
                    $display("FAIL %s: got err=%0b data=%h cyc=%0d, required err=%0b data=%h cyc=%0d",
                             e.name, rsp_err, rsp_rdata, cyc, e.err, e.data, e.due);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    // Called at a negedge; the request is accepted on the following posedge.
    task automatic issue(input string name, input logic wr, input logic [15:0] addr,
                         input logic [15:0] wd, input logic [1:0] be,
                         input logic e_err, input logic [15:0] e_data);
        exp_t e;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        req_be    = be;
        e.name = name;
        e.err  = e_err;
        e.data = e_data;
        e.due  = cyc + READ_LAT;
        expq.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Holds an ignored write request during the sweep and measures its length.
    task automatic measure_init(input string name);
        int n   = 0;
        int rdy = 0;
        int vld = 0;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 16'd200;
        req_wdata = 16'hFFFF;
        req_be    = 2'b11;
        while (init_busy && n < 1000) begin
            if (req_ready) rdy++;
            if (rsp_valid) vld++;
            n++;
            @(negedge clk);
        end
        req_valid = 1'b0;
        check({name, "_len"}, n, DEPTH);
        check({name, "_ready_low"}, rdy, 0);
        check({name, "_no_rsp"}, vld, 0);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
        repeat (3) @(negedge clk);
        check("reset_init_busy", init_busy, 1);
        check("reset_req_ready", req_ready, 0);
        check("reset_rsp", {rsp_valid, rsp_err, rsp_rdata}, 0);
        rst = 1'b0;
        measure_init("init1");

        issue("read19", 1'b0, 16'd19, 16'h0, 2'b00, 1'b0, 16'h0013);
        idle(1);
        check("init_zero_read19", {z_rsp_valid, z_rsp_err, z_rsp_rdata}, {1'b1, 1'b0, 16'h0000});
        idle(2);

        issue("be_wr_lo",  1'b1, 16'd20, 16'hABCD, 2'b01, 1'b0, 16'h0000);
        issue("be_rd_lo",  1'b0, 16'd20, 16'h0,    2'b00, 1'b0, 16'h00CD);
        issue("be_wr_hi",  1'b1, 16'd20, 16'h12FF, 2'b10, 1'b0, 16'h0000);
        issue("be_rd_hi",  1'b0, 16'd20, 16'h0,    2'b00, 1'b0, 16'h12CD);
        idle(3);

        issue("pipe_rd5", 1'b0, 16'd5, 16'h0, 2'b00, 1'b0, 16'h0005);
        issue("pipe_rd6", 1'b0, 16'd6, 16'h0, 2'b00, 1'b0, 16'h0006);
        issue("pipe_rd7", 1'b0, 16'd7, 16'h0, 2'b00, 1'b0, 16'h0007);
        idle(3);

        issue("raw_wr9", 1'b1, 16'd9, 16'hBEEF, 2'b11, 1'b0, 16'h0000);
        issue("raw_rd9", 1'b0, 16'd9, 16'h0,    2'b00, 1'b0, 16'hBEEF);
        idle(3);

        // 300 would alias onto 44 if the address were truncated to 8 bits.
        issue("oor_wr300",  1'b1, 16'd300, 16'h1111, 2'b11, 1'b1, 16'h0000);
        issue("oor_rd300",  1'b0, 16'd300, 16'h0,    2'b00, 1'b1, 16'h0000);
        issue("rd44",       1'b0, 16'd44,  16'h0,    2'b00, 1'b0, 16'h002C);
        issue("be0_wr44",   1'b1, 16'd44,  16'hFFFF, 2'b00, 1'b0, 16'h0000);
        issue("rd44_after", 1'b0, 16'd44,  16'h0,    2'b00, 1'b0, 16'h002C);
        idle(4);

        // Two reads in flight when rst lands: neither may produce a response.
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 16'd20;
        @(negedge clk);
        req_addr  = 16'd21;
        rst       = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        req_valid = 1'b0;
        check("midrst_init_busy", init_busy, 1);
        measure_init("init2");

        issue("post_rst_rd20", 1'b0, 16'd20, 16'h0, 2'b00, 1'b0, 16'h0014);
        issue("post_rst_rd9",  1'b0, 16'd9,  16'h0, 2'b00, 1'b0, 16'h0009);
        idle(1);

        for (int i = 0; i < 20 && expq.size() > 0; i++) @(negedge clk);
        check("drain_empty", expq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required finish before 200000 time units");
        $fatal(1, "watchdog");
    end

endmodule
